// File: rtl/fetch_pkg.sv
// Shared widths, constants and the fetch-buffer entry layout for the fetch front end.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = INSTR_W + XLEN;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0;
  localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small in-order FIFO of fetched {instruction, PC+4} entries with a flush that
// outranks push and pop. Occupancy, not pointer equality, decides full/empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] pushData_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [ENTRY_W-1:0] headData_o,
  output logic [PTR_W:0]     count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop_i)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (push_i && !pop_i) begin
        count_d = count_q + (PTR_W+1)'(1);
      end else if (pop_i && !push_i) begin
        count_d = count_q - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observable once count covers it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  assign headData_o = mem_q[rdPtr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, next-PC mux, fetch buffer and the
// valid/ready handshake towards decode, with branch redirect flushing.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter  logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter  int              BUF_DEPTH = 2,
  parameter  logic [XLEN-1:0] PC_STEP   = 32'd4,
  localparam int              CNT_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]  id_pc_plus4,
  output logic [CNT_W-1:0] buf_count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    pcNext;
  logic               pop;
  logic               fetch;
  fetch_entry_t       newEntry;
  fetch_entry_t       head;
  logic [ENTRY_W-1:0] headBits;

  assign pcNext   = pc_q + PC_STEP;
  assign id_valid = (buf_count != '0);
  assign pop      = id_valid & id_ready;
  // A full buffer may still accept a word when the head leaves in the same cycle.
  assign fetch    = fetch_en & ~br_taken & ((buf_count < DEPTH_C) | pop);

  assign newEntry = '{instr: imem_data, pc_plus4: pcNext};

  always_comb begin
    pc_d = pc_q;
    if (br_taken) begin
      pc_d = br_target;
    end else if (fetch) begin
      pc_d = pcNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) uBuffer (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fetch),
    .pushData_i (newEntry),
    .pop_i      (pop),
    .flush_i    (br_taken),
    .headData_o (headBits),
    .count_o    (buf_count)
  );

  assign head        = headBits;
  assign imem_addr   = pc_q;
  assign id_instr    = id_valid ? head.instr : NOP_INSTR;
  assign id_pc_plus4 = id_valid ? head.pc_plus4 : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference queue predicts every buffered
// entry, PC and occupancy, plus directed checks on stall, redirect, wrap and reset.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        fetchEn;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        brTaken;
  logic [31:0] brTarget;
  logic        idValid;
  logic        idReady;
  logic [31:0] idInstr;
  logic [31:0] idPcPlus4;
  logic [1:0]  bufCount;

  int          vectors;
  int          miscompares;
  logic [63:0] sbQueue [$];
  logic [31:0] modelPc;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2),
    .PC_STEP   (32'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetchEn),
    .imem_addr   (imemAddr),
    .imem_data   (imemData),
    .br_taken    (brTaken),
    .br_target   (brTarget),
    .id_valid    (idValid),
    .id_ready    (idReady),
    .id_instr    (idInstr),
    .id_pc_plus4 (idPcPlus4),
    .buf_count   (bufCount)
  );

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imemData = memWord(imemAddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Compare every observable output against the scoreboard model.
  task automatic compareState();
    checkOutput("imem_addr", 64'(imemAddr), 64'(modelPc));
    checkOutput("buf_count", 64'(bufCount), 64'(sbQueue.size()));
    checkOutput("id_valid", 64'(idValid), 64'(sbQueue.size() != 0));
    if (sbQueue.size() != 0) begin
      checkOutput("id_instr", 64'(idInstr), 64'(sbQueue[0][63:32]));
      checkOutput("id_pc_plus4", 64'(idPcPlus4), 64'(sbQueue[0][31:0]));
    end else begin
      checkOutput("id_instr_idle", 64'(idInstr), 64'h0);
      checkOutput("id_pc_plus4_idle", 64'(idPcPlus4), 64'h0);
    end
  endtask

  // Check current outputs, drive one cycle of inputs, update the model across the edge.
  task automatic applyStimulus(input logic en, input logic rdy, input logic br, input logic [31:0] tgt);
    logic modelPop;
    logic modelFetch;
    compareState();
    fetchEn  = en;
    idReady  = rdy;
    brTaken  = br;
    brTarget = tgt;
    modelPop   = (sbQueue.size() != 0) && rdy;
    modelFetch = en && !br && ((sbQueue.size() < 2) || modelPop);
    if (br) begin
      sbQueue.delete();
      modelPc = tgt;
    end else begin
      if (modelPop) void'(sbQueue.pop_front());
      if (modelFetch) begin
        sbQueue.push_back({memWord(modelPc), modelPc + 32'd4});
        modelPc = modelPc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    modelPc     = 32'h0;
    rst      = 1'b0;
    fetchEn  = 1'b1;
    idReady  = 1'b1;
    brTaken  = 1'b0;
    brTarget = 32'h0;

    // Reset held across edges with fetching requested: nothing may happen.
    repeat (2) @(posedge clk);
    @(negedge clk);
    compareState();
    rst = 1'b1;

    // Streaming from reset.
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Backpressure: buffer fills to two and the PC holds.
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("stall_count", 64'(bufCount), 64'd2);
    checkOutput("stall_pc", 64'(imemAddr), 64'h10);
    checkOutput("stall_head", 64'(idInstr), 64'(memWord(32'h8)));

    // Redirect while full.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h10);
    checkOutput("redir_valid", 64'(idValid), 64'd0);
    checkOutput("redir_count", 64'(bufCount), 64'd0);
    checkOutput("redir_addr", 64'(imemAddr), 64'h10);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_instr", 64'(idInstr), 64'(memWord(32'h10)));
    checkOutput("redir_pc4", 64'(idPcPlus4), 64'h14);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect together with a pop.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    checkOutput("brpop_count", 64'(bufCount), 64'd0);
    checkOutput("brpop_addr", 64'(imemAddr), 64'h40);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Fetch disabled: entries drain, PC frozen.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // PC wraps past the top of the address space.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_addr_top", 64'(imemAddr), 64'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", 64'(imemAddr), 64'h0);
    checkOutput("wrap_pc4", 64'(idPcPlus4), 64'h0);
    checkOutput("wrap_instr", 64'(idInstr), 64'(memWord(32'hFFFF_FFFC)));
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Held redirect and an unaligned target.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h84);
    checkOutput("held_addr", 64'(imemAddr), 64'h84);
    checkOutput("held_count", 64'(bufCount), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h103);
    checkOutput("unaligned_addr", 64'(imemAddr), 64'h103);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Random mix of enable, backpressure and redirects.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 7) == 0), 32'($urandom_range(0, 255)) << 2);
    end

    // Asynchronous reset between edges.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #2 rst = 1'b0;
    #1;
    sbQueue.delete();
    modelPc = 32'h0;
    checkOutput("arst_valid", 64'(idValid), 64'd0);
    checkOutput("arst_count", 64'(bufCount), 64'd0);
    checkOutput("arst_addr", 64'(imemAddr), 64'h0);
    checkOutput("arst_instr", 64'(idInstr), 64'h0);
    checkOutput("arst_pc4", 64'(idPcPlus4), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    compareState();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end. Owns the program counter and drives the combinational instruction memory address. Captures the returned word into a small in-order buffer and presents {instruction, PC+4} to the decode stage over a valid/ready handshake. Taken-branch redirects from later stages flush the buffer and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
BUF_DEPTH, 2, fetch buffer entries (power of two, >=2)
PC_STEP, 4, byte increment per fetched instruction

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
fetch_en  in  1  1 = fetching allowed; 0 = PC holds, no new buffer writes
imem_addr  out  32  byte address to instruction memory; equals the PC register
imem_data  in  32  instruction word returned combinationally for imem_addr in the same cycle
br_taken  in  1  redirect request from execute
br_target  in  32  redirect byte address
id_valid  out  1  buffer head holds a valid instruction
id_ready  in  1  decode accepts the head this cycle
id_instr  out  32  head instruction; 32'h0 when id_valid=0
id_pc_plus4  out  32  address of the head instruction + PC_STEP; 32'h0 when id_valid=0
buf_count  out  $clog2(BUF_DEPTH)+1  occupancy, for debug/perf

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, buffer empty, rd/wr pointers 0, buf_count=0, id_valid=0, id_instr=0, id_pc_plus4=0. No fetch occurs while rst=0.
- pop = id_valid & id_ready.
- fetch = fetch_en & ~br_taken & (buf_count<BUF_DEPTH | pop).
- On fetch: write {imem_data, PC+PC_STEP} at wr pointer; PC <= PC+PC_STEP (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
- On pop: advance rd pointer.
- Simultaneous fetch and pop: occupancy unchanged. A fetch and pop when full is legal.
- Latency: word fetched in cycle t is visible on id_instr/id_valid in cycle t+1 at the earliest. It is presented in strict program order.
- Backpressure: id_ready=0 keeps the head and id_valid stable. The buffer fills to BUF_DEPTH, then the PC holds and no word is lost or duplicated.
- Redirect (br_taken=1 at edge t):
  - Buffer cleared.
  - PC <= br_target. The imem_data of cycle t is discarded.
  - A pop in that cycle is still counted as accepted by decode.
  - br_taken overrides fetch_en and pop for buffer state.
  - Cycle t+1: id_valid=0, imem_addr=br_target.
  - Cycle t+2: target instruction valid (2-cycle penalty).
- br_taken held high for multiple cycles: each cycle reloads PC=br_target and keeps the buffer empty.
- br_target is not alignment-checked. Low bits pass through unchanged.
- fetch_en=0: PC frozen, existing entries still drain to decode.
- Reset mid-operation: everything returns to reset state immediately. The first fetch is from RESET_PC on the first edge after rst deasserts.
- Buffer pointers wrap modulo BUF_DEPTH. Full/empty is decided by buf_count, never by pointer equality alone.

Decomposition:
- Shared package fetch_pkg: XLEN=32, INSTR_W=32, NOP_INSTR=32'h0, default RESET_PC, typedef fetch_entry_t {instr[31:0], pc_plus4[31:0]}.
- One sub-module, fetch_buffer:
  - Parameterised synchronous FIFO of fetch_entry_t with push, pop, flush and count.
  - Flush has priority over push and pop.
  - Same clk/rst convention.
- fetch_stage holds the PC register, the next-PC mux and the handshake glue.

Test Plan:
- Reset release, id_ready=1, fetch_en=1, memory holds words W0..W5 at 0..20 -> imem_addr sequence 0,4,8,..., and id_instr=W0 with id_pc_plus4=4 one cycle after the first fetch. One instruction per cycle thereafter, in order.
- id_ready=0 from cycle 3 for 5 cycles -> buf_count rises to 2, PC holds at the address after the second buffered word, head stable. On release, words resume with none skipped or repeated.
- br_taken=1, br_target=32'h10 while the buffer is full -> next cycle id_valid=0, buf_count=0, imem_addr=32'h10. The cycle after, id_instr=W4 and id_pc_plus4=32'h14.
- br_taken and pop in the same cycle with fetch_en=1 -> buffer empty afterwards, PC=br_target, no stale word appears later.
- PC=32'hFFFF_FFFC fetch -> next imem_addr=0 and id_pc_plus4=0 for that entry.
- rst pulsed low mid-stream, asynchronously between edges -> outputs zero immediately, PC=RESET_PC. Fetch restarts from RESET_PC.
